spi_master_nslave: RTL and testbench

Parametrised SPI master driving up to NUM_SLAVES chip selects from one shared SCLK/MOSI/MISO bus, with runtime-selectable SPI mode (CPOL/CPHA) and a configurable SCLK divider. It replaces the fixed 8-bit, 4-slave master. It sits between the system-side request logic (start/data/done handshake) and the off-block SPI slaves. One transfer addresses exactly one slave, full-duplex, MSB first.

---
 rtl/spi_master_nslave_pkg.sv | 24 ++
 rtl/spi_master_nslave_sclk_gen.sv | 58 +++++
 rtl/spi_master_nslave.sv | 202 ++++++++++++++++++++
 tb/tb_spi_master_nslave.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_nslave_pkg.sv
// spi_pkg: shared types and constants for the spi_master_nslave block.
//   - spi_state_e : master FSM state encoding (IDLE/SETUP/SHIFT/HOLD)
//   - SPI_MODE0..3: SPI mode constants packed as {cpol, cpha}
//   - sel_width() : width of the slave_sel port for a given slave count
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // A single slave still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_nslave_sclk_gen.sv
// spi_sclk_gen: half-period timer for the SPI master.
// Ports:
//   clk, reset_n  system clock, synchronous active-low reset
//   run           count while a transfer is in progress
//   clear         force the counter and half-period phase back to zero
//   edge_en       high while sclk is allowed to toggle (SHIFT state)
//   phase_end     one-cycle strobe in the last cycle of every half-period
//   lead_edge     phase_end that toggles sclk away from its idle level
//   trail_edge    phase_end that returns sclk to its idle level
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  input  logic edge_en,
  output logic phase_end,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int CNT_W = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;

  always_comb begin
    cnt_d      = cnt_q;
    half_d     = half_q;
    phase_end  = run && !clear && (cnt_q == CNT_W'(CLK_DIV - 1));
    // half_q tracks which sclk edge comes next: 0 = leading, 1 = trailing.
    lead_edge  = phase_end && edge_en && !half_q;
    trail_edge = phase_end && edge_en && half_q;
    if (clear || !run) begin
      cnt_d  = '0;
      half_d = 1'b0;
    end else if (phase_end) begin
      cnt_d = '0;
      if (edge_en) begin
        half_d = ~half_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end

endmodule

// File: rtl/spi_master_nslave.sv
// spi_master_nslave: SPI master with NUM_SLAVES chip selects on one shared
// SCLK/MOSI/MISO bus, runtime CPOL/CPHA, MSB-first full-duplex transfers.
// Ports:
//   clk, reset_n       system clock, synchronous active-low reset
//   tx_start           start request (taken only while idle)
//   slave_sel          target chip select, out-of-range requests ignored
//   cpol, cpha         SPI mode, latched with tx_start
//   tx_data / rx_data  word shifted out / last word received
//   busy               transfer in progress
//   tx_done, rx_done   one-cycle completion pulses (asserted together)
//   sclk, mosi, miso   serial bus
//   loopback           only when SPI_LOOPBACK_EN is defined: sample mosi
//                      internally instead of miso
//   cs_n               active-low chip selects
// Optional feature macro: SPI_LOOPBACK_EN.
module spi_master_nslave
  import spi_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NUM_SLAVES = 4,
  parameter  int CLK_DIV    = 2,
  localparam int SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tx_start,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_W-1:0]     tx_data,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  busy,
  output logic                  tx_done,
  output logic                  rx_done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic [NUM_SLAVES-1:0] cs_n
);

  localparam int BC_W = $clog2(DATA_W);

  spi_state_e state_q, state_d;

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;

  logic sel_ok, accept;
  logic phase_end, lead_edge, trail_edge;
  logic sample_now, drive_now, sample_bit;

  // Widen by one bit so the range check stays meaningful when NUM_SLAVES
  // is a power of two.
  assign sel_ok = ({1'b0, slave_sel} < (SEL_W + 1)'(NUM_SLAVES));
  assign accept = (state_q == ST_IDLE) && tx_start && sel_ok;

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback ? mosi_q : miso;
`else
  assign sample_bit = miso;
`endif

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (state_q != ST_IDLE),
    .clear      (state_q == ST_IDLE),
    .edge_en    (state_q == ST_SHIFT),
    .phase_end  (phase_end),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (phase_end) state_d = ST_SHIFT;
      // The last trailing edge closes the shift phase.
      ST_SHIFT: if (trail_edge && (bit_cnt_q == BC_W'(DATA_W - 1))) state_d = ST_HOLD;
      ST_HOLD:  if (phase_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
    cs_n = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (busy && (sel_q == SEL_W'(i))) begin
        cs_n[i] = 1'b0;
      end
    end
  end

  // Shift datapath
  always_comb begin
    sel_d     = sel_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    // CPHA=0 samples on leading edges and shifts on trailing; CPHA=1 swaps.
    sample_now = (state_q == ST_SHIFT) && (cpha_q ? trail_edge : lead_edge);
    drive_now  = (state_q == ST_SHIFT) && (cpha_q ? lead_edge : trail_edge);

    if (accept) begin
      sel_d     = slave_sel;
      cpol_d    = cpol;
      cpha_d    = cpha;
      tx_sr_d   = tx_data;
      rx_sr_d   = '0;
      bit_cnt_d = '0;
      sclk_d    = cpol;
      mosi_d    = tx_data[DATA_W-1];
    end

    if ((state_q == ST_SHIFT) && (lead_edge || trail_edge)) begin
      sclk_d = ~sclk_q;
    end

    if (sample_now) begin
      rx_sr_d = {rx_sr_q[DATA_W-2:0], sample_bit};
    end

    // With CPHA=0 the MSB is already on mosi, so each trailing edge moves to
    // the next bit; with CPHA=1 each leading edge presents the current one.
    if (drive_now) begin
      mosi_d  = cpha_q ? tx_sr_q[DATA_W-1] : tx_sr_q[DATA_W-2];
      tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
    end

    if ((state_q == ST_SHIFT) && trail_edge) begin
      bit_cnt_d = bit_cnt_q + BC_W'(1);
    end

    if ((state_q == ST_HOLD) && phase_end) begin
      rx_data_d = rx_sr_q;
      done_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
    sel_q   <= sel_d;
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
  end

  assign rx_data = rx_data_q;
  assign tx_done = done_q;
  assign rx_done = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_nslave.sv
`timescale 1ns/1ps
module tb_spi_master_nslave;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_n;
  logic [1:0]  mode_i;
  logic [15:0] tx_i;
  logic        miso = 1'b0;
`ifdef SPI_LOOPBACK_EN
  logic        lb_i;
`endif

  // A: default 8-bit / 4 slaves / div 2
  logic       start_a;  logic [1:0] sel_a;  logic [7:0] rx_a;
  logic       busy_a, txd_a, rxd_a, sclk_a, mosi_a;  logic [3:0] cs_a;
  // B: 16-bit / 8 slaves / div 3
  logic       start_b;  logic [2:0] sel_b;  logic [15:0] rx_b;
  logic       busy_b, txd_b, rxd_b, sclk_b, mosi_b;  logic [7:0] cs_b;
  // C: 8-bit / 5 slaves / div 2 (non-power-of-two, out-of-range selects exist)
  logic       start_c;  logic [2:0] sel_c;  logic [7:0] rx_c;
  logic       busy_c, txd_c, rxd_c, sclk_c, mosi_c;  logic [4:0] cs_c;

  spi_master_nslave #(.DATA_W(8), .NUM_SLAVES(4), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .tx_start(start_a), .slave_sel(sel_a),
    .cpol(mode_i[1]), .cpha(mode_i[0]), .tx_data(tx_i[7:0]), .rx_data(rx_a),
    .busy(busy_a), .tx_done(txd_a), .rx_done(rxd_a), .sclk(sclk_a), .mosi(mosi_a),
    .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb_i),
`endif
    .cs_n(cs_a));

  spi_master_nslave #(.DATA_W(16), .NUM_SLAVES(8), .CLK_DIV(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .tx_start(start_b), .slave_sel(sel_b),
    .cpol(mode_i[1]), .cpha(mode_i[0]), .tx_data(tx_i), .rx_data(rx_b),
    .busy(busy_b), .tx_done(txd_b), .rx_done(rxd_b), .sclk(sclk_b), .mosi(mosi_b),
    .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb_i),
`endif
    .cs_n(cs_b));

  spi_master_nslave #(.DATA_W(8), .NUM_SLAVES(5), .CLK_DIV(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .tx_start(start_c), .slave_sel(sel_c),
    .cpol(mode_i[1]), .cpha(mode_i[0]), .tx_data(tx_i[7:0]), .rx_data(rx_c),
    .busy(busy_c), .tx_done(txd_c), .rx_done(rxd_c), .sclk(sclk_c), .mosi(mosi_c),
    .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(lb_i),
`endif
    .cs_n(cs_c));

  // Observed instance, chip selects padded with inactive ones to 8 bits.
  int          which = 0;
  logic        s_busy, s_txd, s_rxd, s_sclk, s_mosi;
  logic [15:0] s_rx;
  logic [7:0]  s_cs;
  always_comb begin
    s_busy = busy_a; s_txd = txd_a; s_rxd = rxd_a; s_sclk = sclk_a; s_mosi = mosi_a;
    s_rx = {8'h00, rx_a}; s_cs = {4'hF, cs_a};
    if (which == 1) begin
      s_busy = busy_b; s_txd = txd_b; s_rxd = rxd_b; s_sclk = sclk_b; s_mosi = mosi_b;
      s_rx = rx_b; s_cs = cs_b;
    end else if (which == 2) begin
      s_busy = busy_c; s_txd = txd_c; s_rxd = rxd_c; s_sclk = sclk_c; s_mosi = mosi_c;
      s_rx = {8'h00, rx_c}; s_cs = {3'b111, cs_c};
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model: shifts resp out and captures mosi per the current mode.
  logic        cur_cpol = 1'b0, cur_cpha = 1'b0;
  logic [15:0] slv_resp = '0, slv_cap = '0;
  int          slv_dw = 8, slv_idx = 0;
  initial begin : slave_model
    logic prev_act, prev_sclk, act, lead;
    prev_act = 1'b0; prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      act = (s_cs != 8'hFF);
      if (act && !prev_act) begin
        slv_idx = slv_dw - 1;
        miso    = slv_resp[slv_idx];
        slv_cap = '0;
      end else if (act && (s_sclk != prev_sclk)) begin
        lead = (s_sclk != cur_cpol);
        if (lead != cur_cpha) begin
          slv_cap = {slv_cap[14:0], s_mosi};
        end else if (cur_cpha) begin
          if (slv_idx >= 0) miso = slv_resp[slv_idx];
          slv_idx--;
        end else begin
          slv_idx--;
          if (slv_idx >= 0) miso = slv_resp[slv_idx];
        end
      end
      prev_act  = act;
      prev_sclk = s_sclk;
    end
  end

  // Scoreboard
  typedef struct {
    logic [15:0] tx;
    logic [15:0] exp_rx;
    logic [7:0]  exp_cs;
    int          exp_cyc;
  } sb_t;
  sb_t sb_q[$];
  int  done_cnt = 0;

  initial begin : monitor
    sb_t  e;
    logic cs_bad;
    cs_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (s_busy && (sb_q.size() != 0) && (s_cs !== sb_q[0].exp_cs)) cs_bad = 1'b1;
      if (s_txd || s_rxd) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done_cnt), 32'(done_cnt - 1));
        end else begin
          e = sb_q.pop_front();
          check("rx_data",    32'(s_rx),            32'(e.exp_rx));
          check("mosi_bits",  32'(slv_cap),         32'(e.tx));
          check("done_cycle", 32'(cyc),             32'(e.exp_cyc));
          check("done_pair",  32'({s_txd, s_rxd}),  32'(2'b11));
          check("cs_pattern", 32'(cs_bad),          32'(0));
          cs_bad = 1'b0;
        end
      end
    end
  end

  typedef struct {
    int          inst;
    int          sel;
    logic [1:0]  mode;
    logic [15:0] tx;
    logic [15:0] resp;
    logic [15:0] exp_rx;
    logic [7:0]  exp_cs;
    int          lat;
  } vec_t;

  // Caller is at a negedge with the target instance idle.
  task automatic start_xfer(input vec_t v, input logic lb, input bit push);
    sb_t e;
    which    = v.inst;
    cur_cpol = v.mode[1];
    cur_cpha = v.mode[0];
    slv_resp = v.resp;
    slv_dw   = (v.inst == 1) ? 16 : 8;
    mode_i   = v.mode;
    tx_i     = v.tx;
`ifdef SPI_LOOPBACK_EN
    lb_i     = lb;
`else
    if (lb) $display("note: loopback requested without SPI_LOOPBACK_EN");
`endif
    case (v.inst)
      1:       begin sel_b = 3'(v.sel); start_b = 1'b1; end
      2:       begin sel_c = 3'(v.sel); start_c = 1'b1; end
      default: begin sel_a = 2'(v.sel); start_a = 1'b1; end
    endcase
    if (push) begin
      e.tx = v.tx; e.exp_rx = v.exp_rx; e.exp_cs = v.exp_cs; e.exp_cyc = cyc + v.lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    check("c1_busy", 32'(s_busy), 32'(1));
    check("c1_cs_n", 32'(s_cs),   32'(v.exp_cs));
    check("c1_sclk", 32'(s_sclk), 32'(v.mode[1]));
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'(0));
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!(s_txd || s_rxd) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(s_txd || s_rxd), 32'(1));
  endtask

  vec_t vecs[6];
  vec_t v;
  int   d0;
  logic bad;

  initial begin
    vecs[0] = '{0, 0, SPI_MODE0, 16'h00AB, 16'h00B7, 16'h00B7, 8'hFE, 37};
    vecs[1] = '{0, 3, SPI_MODE3, 16'h001B, 16'h00AC, 16'h00AC, 8'hF7, 37};
    vecs[2] = '{0, 2, SPI_MODE1, 16'h00FF, 16'h0000, 16'h0000, 8'hFB, 37};
    vecs[3] = '{0, 1, SPI_MODE2, 16'h0000, 16'h00FF, 16'h00FF, 8'hFD, 37};
    vecs[4] = '{1, 5, SPI_MODE1, 16'hBEEF, 16'h1234, 16'h1234, 8'hDF, 103};
    vecs[5] = '{2, 4, SPI_MODE0, 16'h005A, 16'h00C3, 16'h00C3, 8'hEF, 37};

    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    sel_a = '0; sel_b = '0; sel_c = '0;
    mode_i = 2'b00; tx_i = '0;
`ifdef SPI_LOOPBACK_EN
    lb_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs_n",  32'(cs_a),           32'(4'hF));
    check("rst_sclk",  32'(sclk_a),         32'(0));
    check("rst_mosi",  32'(mosi_a),         32'(0));
    check("rst_busy",  32'(busy_a),         32'(0));
    check("rst_done",  32'({txd_a, rxd_a}), 32'(0));
    check("rst_rx",    32'(rx_a),           32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      start_xfer(vecs[i], 1'b0, 1'b1);
      wait_drain(200);
    end

    // Back-to-back: second request issued in the done cycle of the first.
    v = '{0, 0, SPI_MODE0, 16'h003C, 16'h0096, 16'h0096, 8'hFE, 37};
    start_xfer(v, 1'b0, 1'b1);
    wait_done(100);
    v = '{0, 1, SPI_MODE2, 16'h00C5, 16'h0069, 16'h0069, 8'hFD, 37};
    start_xfer(v, 1'b0, 1'b1);
    wait_drain(100);

    // tx_start while busy must not disturb the running transfer.
    v = '{0, 2, SPI_MODE0, 16'h0081, 16'h007E, 16'h007E, 8'hFB, 37};
    start_xfer(v, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    sel_a = 2'd3; tx_i = 16'h00FF; mode_i = SPI_MODE3; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_drain(100);
    d0 = done_cnt;
    repeat (45) @(negedge clk);
    check("busy_ignore_dones", 32'(done_cnt - d0), 32'(0));
    check("busy_ignore_cs_n",  32'(cs_a),          32'(4'hF));

    // Out-of-range selects on the 5-slave instance.
    which = 2;
    d0 = done_cnt;
    bad = 1'b0;
    for (int s = 5; s < 8; s++) begin
      sel_c = 3'(s); tx_i = 16'h00A5; start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      if (busy_c || (cs_c != 5'h1F)) bad = 1'b1;
    end
    repeat (40) begin
      @(negedge clk);
      if (busy_c || (cs_c != 5'h1F)) bad = 1'b1;
    end
    check("oor_busy_or_cs", 32'(bad),               32'(0));
    check("oor_dones",      32'(done_cnt - d0),     32'(0));

    // Reset at cycle 10 of a transfer; rx_a holds 0x7E beforehand.
    v = '{0, 0, SPI_MODE0, 16'h00A5, 16'h005A, 16'h005A, 8'hFE, 37};
    start_xfer(v, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_a),   32'(4'hF));
    check("midrst_sclk", 32'(sclk_a), 32'(0));
    check("midrst_busy", 32'(busy_a), 32'(0));
    check("midrst_rx",   32'(rx_a),   32'(0));
    check("midrst_mosi", 32'(mosi_a), 32'(0));
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_dones", 32'(done_cnt - d0), 32'(0));

`ifdef SPI_LOOPBACK_EN
    v = '{1, 5, SPI_MODE1, 16'hBEEF, 16'h1234, 16'hBEEF, 8'hDF, 103};
    start_xfer(v, 1'b1, 1'b1);
    wait_drain(200);
    lb_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
